fib_sequencer: RTL and testbench
================================

Name: fib_sequencer

Overview:
Parametrised Fibonacci sequence generator that fills a register file. It generates the sequence itself and drives a one-hot register-enable and write-data bus into the regfile; the ALU is not in this path. It generalises the fixed 16-register, 16-bit Fibonacci test FSM in four ways: width, depth, seeds and overflow mode are all configurable. It also adds a start/done handshake, single-step mode, abort and a sticky overflow flag.

Parameters:
WIDTH, 16, data width of regfile entries and wr_data
NUM_REGS, 16, number of registers filled; legal range 3..256
SATURATE, 0, 0 = wrap sums modulo 2^WIDTH, 1 = clamp sums to 2^WIDTH-1
Derived: AW = $clog2(NUM_REGS)

Ports:
clk  in  1  single system clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin a run; sampled only in IDLE
abort  in  1  synchronous cancel of a run in progress
step_mode  in  1  1 = advance one write per step pulse
step  in  1  advance strobe, used only when step_mode=1
seed0  in  WIDTH  value written to register 0; latched on accepted start
seed1  in  WIDTH  value written to register 1; latched on accepted start
reg_enable  out  NUM_REGS  one-hot write enable to the regfile; all-zero when not writing
wr_addr  out  AW  index of the register being written (binary form of reg_enable)
wr_data  out  WIDTH  data for the register being written
busy  out  1  high in SEED0, SEED1 and COMPUTE
done  out  1  one-cycle pulse when the final register has been written
overflow  out  1  sticky; set when any true sum exceeds 2^WIDTH-1; cleared on accepted start

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; reg_enable=0, wr_addr=0, wr_data=0, busy=0, done=0, overflow=0.
  - Internal registers prev, curr and idx are cleared.
- States: IDLE, SEED0, SEED1, COMPUTE, DONE.
- Advance qualifier: adv = (step_mode==0) | step. In SEED0, SEED1 and COMPUTE:
  - A write happens only in a cycle with adv=1.
  - When adv=0, reg_enable=0 and all state is held.
- IDLE:
  - start=1 latches seed0/seed1, clears overflow, sets idx=0 and moves to SEED0.
  - No write occurs in the start cycle.
- SEED0 (write cycle):
  - reg_enable=1<<0, wr_addr=0, wr_data=seed0.
  - prev<=seed0, idx<=1, go to SEED1.
- SEED1 (write cycle):
  - reg_enable=1<<1, wr_data=seed1.
  - curr<=seed1, idx<=2, go to COMPUTE.
- COMPUTE (write cycle):
  - sum = prev + curr, computed at WIDTH+1 bits.
  - If sum[WIDTH]=1: overflow<=1. With SATURATE=0, write sum[WIDTH-1:0]; with SATURATE=1, write all-ones.
  - reg_enable=1<<idx, wr_data=written value.
  - prev<=curr, curr<=written value (later terms use the truncated or saturated values).
  - If idx==NUM_REGS-1, go to DONE; otherwise idx<=idx+1.
- DONE: done=1 for exactly one cycle, no write, then IDLE.
- Outputs are combinational decodes of registered state, so a write is visible in the same cycle as its state.
- Latency with free-run and NUM_REGS=N: start accepted at cycle 0; writes on cycles 1..N; done on cycle N+1; IDLE on cycle N+2.
- Boundary conditions:
  - start while not in IDLE is ignored, including in DONE.
  - abort=1 in SEED0/SEED1/COMPUTE: no write that cycle, IDLE next cycle, no done pulse, overflow keeps its value.
  - abort has priority over adv.
  - abort in IDLE or DONE is ignored.
  - Simultaneous start and abort in IDLE: start wins.
  - step held high with step_mode=1 advances every cycle, same as free-run.
  - step_mode may change mid-run and takes effect the same cycle.
  - reset mid-run returns immediately to the reset values above.
  - reg_enable is never multi-hot and never addresses an index ≥ NUM_REGS.

Test Plan:
1. Defaults, seeds 0/1, start pulse, step_mode=0 -> writes 0,1,1,2,3,5,...,377,610 to regs 0..15 on cycles 1..16; done at cycle 17; overflow=0.
2. WIDTH=8, NUM_REGS=16, SATURATE=0, seeds 0/1 -> reg13=233, reg14=121, reg15=98; overflow set at the reg14 write and still 1 after done.
3. Same config with SATURATE=1 -> reg14=255, reg15=255; overflow=1.
4. step_mode=1, three step pulses spaced 4 cycles apart after start -> exactly three writes (regs 0,1,2 = 0,1,1); reg_enable=0 in all other cycles; busy stays 1.
5. abort asserted during the reg7 write cycle -> no write that cycle, IDLE next cycle, no done pulse. A second start during the run is ignored; a new start from IDLE begins again at reg0.
6. reset driven low mid-COMPUTE, asynchronously between clock edges -> outputs go to zero immediately. After reset is released, a new start with seeds 2/3 writes 2,3,5,8,... from reg0.

Source files
------------

// File: rtl/fib_sequencer.sv
// -----------------------------------------------------------------------------
// fib_sequencer
//
// Purpose:
//   Fills a register file with a Fibonacci sequence. The block generates the
//   terms itself and presents them on a one-hot register-enable bus plus a
//   binary address and a write-data bus. Width, depth, the two seed values and
//   the overflow behaviour (wrap or clamp) are configurable. A run is started
//   with a start/done handshake. It can be advanced one write per step pulse,
//   and it can be cancelled with abort. A sticky flag records any sum that
//   did not fit in WIDTH bits.
//
// Parameters:
//   WIDTH     data width of the regfile entries and of wr_data
//   NUM_REGS  number of registers filled (3..256)
//   SATURATE  0 = sums wrap modulo 2^WIDTH, 1 = sums clamp to all-ones
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   begin a run (accepted only while idle)
//   abort      in   cancel a run in progress (synchronous)
//   step_mode  in   1 = one write per step pulse
//   step       in   advance strobe while step_mode=1
//   seed0      in   value for register 0, latched when start is accepted
//   seed1      in   value for register 1, latched when start is accepted
//   reg_enable out  one-hot regfile write enable, zero when not writing
//   wr_addr    out  binary index of the register being written
//   wr_data    out  data for the register being written
//   busy       out  high while the run is writing registers
//   done       out  one-cycle pulse after the final register is written
//   overflow   out  sticky sum-overflow flag, cleared on accepted start
// -----------------------------------------------------------------------------

// Runtime property checker for the write interface. It holds no design state.
module fib_sequencer_checker #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REGS-1:0] reg_enable,
    input  logic [AW-1:0]       wr_addr,
    input  logic                busy,
    input  logic                done
);

    // The regfile must never see two registers enabled at once.
    a_onehot : assert property (@(posedge clk) disable iff (!reset)
        $onehot0(reg_enable));

    // The binary address must agree with the one-hot enable during a write.
    a_addr_match : assert property (@(posedge clk) disable iff (!reset)
        (reg_enable != '0) |-> (reg_enable == (NUM_REGS'(1) << wr_addr)));

    // Writes occur only in the busy states.
    a_write_busy : assert property (@(posedge clk) disable iff (!reset)
        (reg_enable != '0) |-> busy);

    // The completion pulse never coincides with a write or with busy.
    a_done_quiet : assert property (@(posedge clk) disable iff (!reset)
        done |-> ((reg_enable == '0) && !busy));

endmodule

module fib_sequencer #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned SATURATE = 0,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                step_mode,
    input  logic                step,
    input  logic [WIDTH-1:0]    seed0,
    input  logic [WIDTH-1:0]    seed1,
    output logic [NUM_REGS-1:0] reg_enable,
    output logic [AW-1:0]       wr_addr,
    output logic [WIDTH-1:0]    wr_data,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEED0   = 3'd1,
        ST_SEED1   = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    // Registered state.
    state_e             state_q;
    logic [WIDTH-1:0]   prev_q;      // older of the two most recent terms
    logic [WIDTH-1:0]   curr_q;      // newer of the two most recent terms
    logic [AW-1:0]      idx_q;       // register index of the next write
    logic               overflow_q;

    // Combinational helpers.
    logic               adv_s;
    logic               in_run_s;
    logic               wr_active_s;
    logic [WIDTH:0]     sum_s;
    logic               carry_s;
    logic [WIDTH-1:0]   comp_val_s;
    logic [WIDTH-1:0]   wr_val_s;

    // Advance qualifier and run/write gating. Abort suppresses the write of its cycle.
    always_comb begin
        adv_s       = (~step_mode) | step;
        in_run_s    = (state_q == ST_SEED0) || (state_q == ST_SEED1) ||
                      (state_q == ST_COMPUTE);
        wr_active_s = in_run_s & adv_s & ~abort;
    end

    // Next Fibonacci term. The sum carries one extra bit so overflow can be detected.
    always_comb begin
        sum_s   = {1'b0, prev_q} + {1'b0, curr_q};
        carry_s = sum_s[WIDTH];
        if (carry_s && (SATURATE != 0)) begin
            comp_val_s = {WIDTH{1'b1}};
        end else begin
            comp_val_s = sum_s[WIDTH-1:0];
        end
    end

    // Select the value written in the current state.
    // The seeds were already loaded into prev/curr when start was accepted.
    always_comb begin
        wr_val_s = '0;
        case (state_q)
            ST_SEED0:   wr_val_s = prev_q;
            ST_SEED1:   wr_val_s = curr_q;
            ST_COMPUTE: wr_val_s = comp_val_s;
            default:    wr_val_s = '0;
        endcase
    end

    // Output decode of registered state, gated by the write qualifier.
    always_comb begin
        if (wr_active_s) begin
            reg_enable = NUM_REGS'(1) << idx_q;
            wr_addr    = idx_q;
            wr_data    = wr_val_s;
        end else begin
            reg_enable = '0;
            wr_addr    = '0;
            wr_data    = '0;
        end
        busy     = in_run_s;
        done     = (state_q == ST_DONE);
        overflow = overflow_q;
    end

    // Sequencer FSM and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            prev_q     <= '0;
            curr_q     <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Latch both seeds now so later seed input changes cannot affect the run.
                    if (start) begin
                        prev_q     <= seed0;
                        curr_q     <= seed1;
                        idx_q      <= '0;
                        overflow_q <= 1'b0;
                        state_q    <= ST_SEED0;
                    end else begin
                        state_q    <= ST_IDLE;
                    end
                end
                ST_SEED0: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else if (adv_s) begin
                        idx_q   <= AW'(1);
                        state_q <= ST_SEED1;
                    end else begin
                        state_q <= ST_SEED0;
                    end
                end
                ST_SEED1: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else if (adv_s) begin
                        idx_q   <= AW'(2);
                        state_q <= ST_COMPUTE;
                    end else begin
                        state_q <= ST_SEED1;
                    end
                end
                ST_COMPUTE: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else if (adv_s) begin
                        if (carry_s) begin
                            overflow_q <= 1'b1;
                        end else begin
                            overflow_q <= overflow_q;
                        end
                        // Later terms are built from the value actually written.
                        prev_q <= curr_q;
                        curr_q <= comp_val_s;
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_DONE;
                        end else begin
                            idx_q   <= idx_q + AW'(1);
                            state_q <= ST_COMPUTE;
                        end
                    end else begin
                        state_q <= ST_COMPUTE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    fib_sequencer_checker #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_checker (
        .clk        (clk),
        .reset      (reset),
        .reg_enable (reg_enable),
        .wr_addr    (wr_addr),
        .busy       (busy),
        .done       (done)
    );

endmodule

// File: tb/tb_fib_sequencer.sv
`timescale 1ns/1ps
module tb_fib_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, abort, step_mode, step;
    logic [15:0] seed0, seed1;

    wire [15:0] en0, en1, en2;
    wire [3:0]  ad0, ad1, ad2;
    wire [15:0] wd0;
    wire [7:0]  wd1, wd2;
    wire        bz0, bz1, bz2, dn0, dn1, dn2, ov0, ov1, ov2;

    // d0: default 16-bit wrap, d1: 8-bit wrap, d2: 8-bit saturate
    fib_sequencer u_d0 (.clk(clk), .reset(reset), .start(start), .abort(abort),
        .step_mode(step_mode), .step(step), .seed0(seed0), .seed1(seed1),
        .reg_enable(en0), .wr_addr(ad0), .wr_data(wd0), .busy(bz0), .done(dn0), .overflow(ov0));
    fib_sequencer #(.WIDTH(8), .NUM_REGS(16), .SATURATE(0)) u_d1 (.clk(clk), .reset(reset),
        .start(start), .abort(abort), .step_mode(step_mode), .step(step),
        .seed0(seed0[7:0]), .seed1(seed1[7:0]),
        .reg_enable(en1), .wr_addr(ad1), .wr_data(wd1), .busy(bz1), .done(dn1), .overflow(ov1));
    fib_sequencer #(.WIDTH(8), .NUM_REGS(16), .SATURATE(1)) u_d2 (.clk(clk), .reset(reset),
        .start(start), .abort(abort), .step_mode(step_mode), .step(step),
        .seed0(seed0[7:0]), .seed1(seed1[7:0]),
        .reg_enable(en2), .wr_addr(ad2), .wr_data(wd2), .busy(bz2), .done(dn2), .overflow(ov2));

    int n_cmp = 0;
    int n_bad = 0;

    longint exp_v  [3][16];  // expected term values per DUT
    bit     exp_ov [3][17];  // exp_ov[d][k]: overflow after k writes
    longint cap    [3][16];  // values captured from the write bus

    typedef struct {
        int     reg_i;
        longint v16;
        longint v8w;
        longint v8s;
    } vec_t;
    vec_t tbl [8];

    function automatic longint g_en(int d);
        case (d) 0: return longint'(en0); 1: return longint'(en1); default: return longint'(en2); endcase
    endfunction
    function automatic longint g_ad(int d);
        case (d) 0: return longint'(ad0); 1: return longint'(ad1); default: return longint'(ad2); endcase
    endfunction
    function automatic longint g_wd(int d);
        case (d) 0: return longint'(wd0); 1: return longint'(wd1); default: return longint'(wd2); endcase
    endfunction
    function automatic longint g_bz(int d);
        case (d) 0: return longint'(bz0); 1: return longint'(bz1); default: return longint'(bz2); endcase
    endfunction
    function automatic longint g_dn(int d);
        case (d) 0: return longint'(dn0); 1: return longint'(dn1); default: return longint'(dn2); endcase
    endfunction
    function automatic longint g_ov(int d);
        case (d) 0: return longint'(ov0); 1: return longint'(ov1); default: return longint'(ov2); endcase
    endfunction

    task automatic chk(input string name, input int d, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[d%0d] @%0t: got %0d expected %0d", name, d, $time, act, exp);
        end
    endtask

    // Reference: plain Fibonacci arithmetic per configuration.
    task automatic gen_model(input longint s0, input longint s1);
        for (int d = 0; d < 3; d++) begin
            longint mx;
            bit     sat;
            mx  = (d == 0) ? 64'd65535 : 64'd255;
            sat = (d == 2);
            exp_v[d][0] = s0 & mx;
            exp_v[d][1] = s1 & mx;
            exp_ov[d][0] = 1'b0; exp_ov[d][1] = 1'b0; exp_ov[d][2] = 1'b0;
            for (int j = 2; j < 16; j++) begin
                longint t;
                bit     o;
                t = exp_v[d][j-2] + exp_v[d][j-1];
                o = (t > mx);
                if (o) t = sat ? mx : (t - (mx + 64'd1));
                exp_v[d][j] = t;
                exp_ov[d][j+1] = exp_ov[d][j] | o;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One complete run from an accepted start to return to idle. Entered and left at posedge+1.
    task automatic run(input logic [15:0] s0, input logic [15:0] s1, input bit rnd_step,
                       input bit abort_too, input bit start_in_done);
        int k;
        bit adv;
        gen_model(longint'(s0), longint'(s1));
        seed0 = s0; seed1 = s1; start = 1'b1; abort = abort_too; step_mode = 1'b0; step = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("start_cycle_busy", d, g_bz(d), 64'd0);
            chk("start_cycle_en", d, g_en(d), 64'd0);
        end
        cycle();
        start = 1'b0; abort = 1'b0; seed0 = 16'($urandom); seed1 = 16'($urandom);
        k = 0;
        for (int c = 0; c < 400 && k < 16; c++) begin
            if (rnd_step) begin
                step_mode = ($urandom_range(0, 3) != 0);
                step      = 1'($urandom_range(0, 1));
            end
            adv = !step_mode || step;
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk("run_busy", d, g_bz(d), 64'd1);
                chk("run_ovf", d, g_ov(d), longint'(exp_ov[d][k]));
                if (adv) begin
                    chk("run_en", d, g_en(d), 64'd1 << k);
                    chk("run_addr", d, g_ad(d), longint'(k));
                    chk("run_data", d, g_wd(d), exp_v[d][k]);
                    cap[d][k] = g_wd(d);
                end else begin
                    chk("idle_step_en", d, g_en(d), 64'd0);
                end
            end
            if (adv) k++;
            cycle();
        end
        if (k < 16) begin
            n_cmp++; n_bad++;
            $display("FAIL run_timeout: got %0d writes expected 16", k);
        end
        step_mode = 1'b0; step = 1'b0; start = start_in_done;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("done_pulse", d, g_dn(d), 64'd1);
            chk("done_busy", d, g_bz(d), 64'd0);
            chk("done_en", d, g_en(d), 64'd0);
            chk("done_ovf", d, g_ov(d), longint'(exp_ov[d][16]));
        end
        cycle();
        start = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("after_done", d, g_dn(d), 64'd0);
            chk("after_busy", d, g_bz(d), 64'd0);
            chk("after_en", d, g_en(d), 64'd0);
        end
        cycle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 0, 0, 0};
        tbl[1] = '{1, 1, 1, 1};
        tbl[2] = '{2, 1, 1, 1};
        tbl[3] = '{7, 13, 13, 13};
        tbl[4] = '{12, 144, 144, 144};
        tbl[5] = '{13, 233, 233, 233};
        tbl[6] = '{14, 377, 121, 255};
        tbl[7] = '{15, 610, 98, 255};

        reset = 1'b0; start = 1'b0; abort = 1'b0; step_mode = 1'b0; step = 1'b0;
        seed0 = 16'd0; seed1 = 16'd0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_en", d, g_en(d), 64'd0);
            chk("rst_addr", d, g_ad(d), 64'd0);
            chk("rst_data", d, g_wd(d), 64'd0);
            chk("rst_busy", d, g_bz(d), 64'd0);
            chk("rst_done", d, g_dn(d), 64'd0);
            chk("rst_ovf", d, g_ov(d), 64'd0);
        end
        cycle();
        reset = 1'b1;
        cycle();

        // Seeds 0/1 free-run on all three configurations, start in DONE ignored.
        run(16'd0, 16'd1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("tbl_w16", 0, cap[0][tbl[i].reg_i], tbl[i].v16);
            chk("tbl_w8_wrap", 1, cap[1][tbl[i].reg_i], tbl[i].v8w);
            chk("tbl_w8_sat", 2, cap[2][tbl[i].reg_i], tbl[i].v8s);
        end
        chk("ovf_sticky_w16", 0, g_ov(0), 64'd0);
        chk("ovf_sticky_w8w", 1, g_ov(1), 64'd1);
        chk("ovf_sticky_w8s", 2, g_ov(2), 64'd1);

        // Step mode: three pulses four cycles apart.
        seed0 = 16'd0; seed1 = 16'd1; step_mode = 1'b1; step = 1'b0; start = 1'b1;
        cycle();
        start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            longint e_en;
            longint e_wd;
            step = (c == 2) || (c == 6) || (c == 10);
            e_en = (c == 2) ? 64'd1 : (c == 6) ? 64'd2 : (c == 10) ? 64'd4 : 64'd0;
            e_wd = (c == 2) ? 64'd0 : 64'd1;
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk("step_busy", d, g_bz(d), 64'd1);
                chk("step_en", d, g_en(d), e_en);
                if (e_en != 64'd0) chk("step_data", d, g_wd(d), e_wd);
            end
            cycle();
        end
        step = 1'b0; abort = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk("step_abort_en", d, g_en(d), 64'd0);
        cycle();
        abort = 1'b0; step_mode = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk("step_abort_busy", d, g_bz(d), 64'd0);
        cycle();

        // Abort on the reg7 write; re-start at cycle 3 is ignored.
        seed0 = 16'd200; seed1 = 16'd100; start = 1'b1;
        cycle();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            start = (c == 3);
            abort = (c == 8);
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk("abort_run_busy", d, g_bz(d), 64'd1);
                if (c < 8) begin
                    chk("abort_run_addr", d, g_ad(d), longint'(c - 1));
                    chk("abort_run_en", d, g_en(d), 64'd1 << (c - 1));
                end else begin
                    chk("abort_cycle_en", d, g_en(d), 64'd0);
                end
            end
            cycle();
        end
        start = 1'b0; abort = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk("abort_idle_busy", d, g_bz(d), 64'd0);
                chk("abort_no_done", d, g_dn(d), 64'd0);
                chk("abort_idle_en", d, g_en(d), 64'd0);
                chk("abort_keep_ovf", d, g_ov(d), (d == 0) ? 64'd0 : 64'd1);
            end
            cycle();
        end
        run(16'd0, 16'd1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of COMPUTE.
        seed0 = 16'd0; seed1 = 16'd1; start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (5) cycle();
        #2;
        chk("pre_reset_addr", 0, g_ad(0), 64'd5);
        reset = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("mid_rst_en", d, g_en(d), 64'd0);
            chk("mid_rst_addr", d, g_ad(d), 64'd0);
            chk("mid_rst_data", d, g_wd(d), 64'd0);
            chk("mid_rst_busy", d, g_bz(d), 64'd0);
            chk("mid_rst_ovf", d, g_ov(d), 64'd0);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        cycle();
        run(16'd2, 16'd3, 1'b0, 1'b0, 1'b0);

        // Randomized runs: random seeds, random step/step_mode, start+abort collisions.
        for (int r = 0; r < 6; r++) begin
            run(16'($urandom), 16'($urandom), 1'b1, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
